// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32I byte-addressed load/store unit driving a word-addressed data memory
module dmem_lsu #(
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rW,
    output logic        mem_en,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(READ_LAT + 1);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          we;
    logic [2:0]    f3;
    logic [1:0]    lane;
    logic          accept, err, ld_bad, st_bad, rd_done;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   load_data, merged;

    assign accept     = req_valid && req_ready;
    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = state == RESP;
    // gated by rst so a write caught by reset never reaches memory
    assign mem_en     = (state == RD_ISSUE || state == WR_ISSUE) && !rst;
    assign rd_done    = state == RD_WAIT && cnt == '0;

    assign ld_bad = req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11
                 || (req_funct3[1:0] == 2'b01 && req_addr[0])
                 || (req_funct3 == 3'b010 && |req_addr[1:0]);
    assign st_bad = req_funct3 > 3'b010
                 || (req_funct3 == 3'b001 && req_addr[0])
                 || (req_funct3 == 3'b010 && |req_addr[1:0]);
    assign err    = req_we ? st_bad : ld_bad;

    assign byte_v    = 8'(mem_rdata >> {lane, 3'b000});
    assign half_v    = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign load_data = f3[1] ? mem_rdata
                     : f3[0] ? {{16{half_v[15] & ~f3[2]}}, half_v}
                     : {{24{byte_v[7] & ~f3[2]}}, byte_v};
    // mem_wdata still holds the raw store data until the merge is written back
    assign merged    = f3[0] ? (lane[1] ? {mem_wdata[15:0], mem_rdata[15:0]}
                                        : {mem_rdata[31:16], mem_wdata[15:0]})
                     : (mem_rdata & ~(32'hFF << {lane, 3'b000}))
                       | ({24'd0, mem_wdata[7:0]} << {lane, 3'b000});

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (accept) state_next = err ? RESP
                                 : (req_we && req_funct3 == 3'b010) ? WR_ISSUE : RD_ISSUE;
            RD_ISSUE: state_next = RD_WAIT;
            RD_WAIT:  if (cnt == '0) state_next = we ? WR_ISSUE : RESP;
            WR_ISSUE: state_next = RESP;
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            we         <= 1'b0;
            f3         <= 3'b000;
            lane       <= 2'b00;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_rW     <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                we         <= req_we;
                f3         <= req_funct3;
                lane       <= req_addr[1:0];
                mem_addr   <= {2'b00, req_addr[31:2]};
                mem_wdata  <= req_wdata;
                resp_rdata <= '0;
                resp_err   <= err;
            end
            if (state == RD_ISSUE) cnt <= CW'(READ_LAT - 1);
            else if (state == RD_WAIT && cnt != '0) cnt <= cnt - 1'b1;
            if (state_next == RD_ISSUE) mem_rW <= 1'b0;
            if (state_next == WR_ISSUE) mem_rW <= 1'b1;
            if (rd_done) begin
                if (we) mem_wdata <= merged;
                else resp_rdata <= load_data;
            end
        end
    end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit sitting directly upstream of the banked data memory (top_dmem); accepts byte-addressed RV32I load/store requests from the execute stage.
- Converts each request to word accesses using top_dmem's word address, rW and en signals.
- Loads: extracts and sign/zero-extends the addressed byte or halfword.
- Sub-word stores: read-modify-write. Misaligned accesses and illegal funct3 codes are rejected without touching memory.

Parameters:
- READ_LAT, 2, cycles from the read-issue cycle to valid mem_rdata (≥1; 2 matches top_dmem).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low byte/half used for SB/SH)
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal funct3
- mem_addr  out  32  word address = {2'b00, req_addr[31:2]}
- mem_wdata  out  32  write word
- mem_rW  out  1  1=write, 0=read
- mem_en  out  1  access strobe
- mem_rdata  in  32  read word from top_dmem

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous, active-high.
- Reset state: IDLE. resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_rW, mem_en are all 0. req_ready is 0 while rst is high.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
- Handshake and decode:
  - req_ready = (state==IDLE) && !rst.
  - Accept on the edge where req_valid && req_ready; latch all request fields. req_valid while busy is ignored.
- Transitions from IDLE on accept:
  - error → RESP
  - load, SB, SH → RD_ISSUE
  - SW → WR_ISSUE
- Error conditions:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
  - Load funct3 ∈ {011, 110, 111}.
  - Store funct3 ≥ 011.
- RD_ISSUE (1 cycle): mem_en=1, mem_rW=0 → RD_WAIT.
- RD_WAIT (READ_LAT cycles, down-counter loaded with READ_LAT-1):
  - Sample mem_rdata on the edge ending the last wait cycle.
  - Load → RESP with extracted data.
  - SB/SH → build merged word into mem_wdata → WR_ISSUE.
- WR_ISSUE (1 cycle): mem_en=1, mem_rW=1 → RESP.
- RESP (1 cycle): resp_valid=1 → IDLE. resp_valid is 0 in all other states.
- mem_en is high only in RD_ISSUE and WR_ISSUE, exactly one cycle per access.
- Memory-signal stability:
  - mem_rW changes only on entry to RD_ISSUE (→0) or WR_ISSUE (→1), and is otherwise held. This keeps it stable for top_dmem's registered enables.
  - mem_addr and mem_wdata are loaded on accept (mem_wdata = req_wdata for SW) and held until the next accept.
- Load extraction (lane = addr[1:0]):
  - LB/LBU: byte rdata[8*lane+7:8*lane], sign- or zero-extended.
  - LH/LHU: half rdata[16*addr[1]+15:16*addr[1]], sign- or zero-extended.
  - LW: whole word.
- Store merge:
  - SB replaces byte lane with wdata[7:0].
  - SH replaces half addr[1] with wdata[15:0].
  - Other bytes come from the read word.
- Latency (cycles after the accept edge to resp_valid):
  - error: 1
  - SW: 2
  - load: 2+READ_LAT
  - SB/SH: 3+READ_LAT
- Back-to-back: the next request is accepted in the cycle after RESP (IDLE).
- Reset mid-operation: the in-flight request is dropped and no response is issued. mem_en is 0 from the edge rst is sampled; any partial RMW write is never issued.

Test Plan (behavioural top_dmem model, READ_LAT=2):
1. Reset: rst high 2 cycles → all outputs 0, req_ready 0; after release req_ready=1.
2. SW addr 0x104 data 0xDEADBEEF → mem_addr 0x41, mem_wdata 0xDEADBEEF, single-cycle mem_en with mem_rW=1, resp_valid cycle 2, resp_err 0. Then LW 0x104 → resp_rdata 0xDEADBEEF at cycle 4, one mem_en with mem_rW=0.
3. Load extraction on that word:
   - LB 0x107 → 0xFFFFFFDE
   - LBU 0x107 → 0x000000DE
   - LH 0x106 → 0xFFFFDEAD
   - LHU 0x104 → 0x0000BEEF
4. RMW:
   - SB 0x105 data 0x12 → read then write 0xDEAD12EF, resp_valid cycle 5.
   - SH 0x106 data 0xCAFE → 0xCAFE12EF.
   - LW confirms 0xCAFE12EF.
5. Errors, each → resp_valid cycle 1, resp_err 1, resp_rdata 0, mem_en never asserted:
   - LW 0x102
   - SH 0x101
   - load funct3 011
6. rst pulsed during RD_WAIT of LW, and separately during WR_ISSUE of SB → no resp_valid, mem_en 0 after the reset edge, req_ready 1 the cycle after rst falls; a subsequent LW completes normally.
